// File: rtl/mandel_pkg.sv
// Shared types and frame geometry for the Mandelbrot engine array and its
// line buffering / colour stages.
package mandel_pkg;

   localparam int LINE_WIDTH = 640;
   localparam int LINES      = 480;
   localparam int DEPTH_W    = 10;

   typedef enum logic [1:0] {
      EMPTY,
      FILLING,
      FULL,
      DRAINING
   } bank_state_t;

   typedef enum logic {
      W_WAIT,
      W_BUSY
   } wr_state_t;

   typedef enum logic {
      R_IDLE,
      R_DRAIN
   } rd_state_t;

endpackage

// File: rtl/depth_bank_ram.sv
// Two-bank depth store: simple dual-port, registered write, 1-cycle read.
// Address is {bank, x}; bank 1 is packed directly after bank 0.
module depth_bank_ram #(
   parameter int LINE_WIDTH = 640,
   parameter int DEPTH_W    = 10,
   parameter int ADDR_W     = 10
) (
   input  logic               aclk,
   input  logic               we,
   input  logic [ADDR_W:0]    wr_addr,
   input  logic [DEPTH_W-1:0] wr_data,
   input  logic               re,
   input  logic [ADDR_W:0]    rd_addr,
   output logic [DEPTH_W-1:0] rd_data
);

   localparam int WORDS = 2 * LINE_WIDTH;
   localparam int IDX_W = $clog2(WORDS);

   logic [DEPTH_W-1:0] mem [WORDS];

   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W:0] a);
      if (a[ADDR_W])
         return IDX_W'(LINE_WIDTH) + IDX_W'(a[ADDR_W-1:0]);
      return IDX_W'(a[ADDR_W-1:0]);
   endfunction

   always_ff @(posedge aclk) begin
      if (we)
         mem[word_idx(wr_addr)] <= wr_data;
      if (re)
         rd_data <= mem[word_idx(rd_addr)];
   end

endmodule

// File: rtl/depth_line_buffer.sv
// Ping-pong line buffer: engines fill one bank out of order while the other
// bank streams in pixel order through a 2-entry skid queue.
module depth_line_buffer #(
   parameter int LINE_WIDTH = mandel_pkg::LINE_WIDTH,
   parameter int LINES      = mandel_pkg::LINES,
   parameter int DEPTH_W    = mandel_pkg::DEPTH_W,
   parameter int ADDR_W     = $clog2(LINE_WIDTH),
   parameter int Y_W        = $clog2(LINES)
) (
   input  logic               out_stream_aclk,
   input  logic               periph_resetn,
   input  logic               wr_en,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [DEPTH_W-1:0] wr_depth,
   input  logic               wr_line_done,
   output logic               start_line,
   output logic [DEPTH_W-1:0] rd_depth,
   output logic               rd_valid,
   input  logic               rd_ready,
   output logic               rd_eol,
   output logic               rd_sof,
   output logic [Y_W-1:0]     rd_y,
   output logic               err
);

   import mandel_pkg::*;

   localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(LINE_WIDTH - 1);
   localparam logic [Y_W-1:0]    Y_LAST = Y_W'(LINES - 1);

   wr_state_t         wr_st;
   rd_state_t         rd_st;
   bank_state_t       bank_st [2];
   logic              wb;
   logic              rb;
   logic [ADDR_W-1:0] x_fetch;
   logic              fetching;

   logic               vld_p0;
   logic               eol_p0;
   logic               sof_p0;
   logic [DEPTH_W-1:0] depth_p0;

   logic [1:0]         q_cnt;
   logic [DEPTH_W-1:0] hd_depth;
   logic               hd_eol;
   logic               hd_sof;
   logic [DEPTH_W-1:0] tl_depth;
   logic               tl_eol;
   logic               tl_sof;

   logic addr_ok;
   logic ram_we;
   logic pop;
   logic last_pop;
   logic room;
   logic fetch;

   assign addr_ok  = (wr_addr <= X_LAST);
   assign ram_we   = (wr_st == W_BUSY) && wr_en && addr_ok;
   assign rd_valid = (q_cnt != 2'd0);
   assign pop      = rd_valid && rd_ready;
   assign last_pop = pop && hd_eol;
   // A fetch is only issued if the queue can still absorb it once the word
   // already in the RAM read stage has landed.
   assign room     = (({1'b0, q_cnt} + {2'b00, vld_p0}) - {2'b00, pop}) < 3'd2;
   assign fetch    = (rd_st == R_DRAIN) && fetching && room;

   assign rd_depth = hd_depth;
   assign rd_eol   = rd_valid && hd_eol;
   assign rd_sof   = rd_valid && hd_sof;

   depth_bank_ram #(
      .LINE_WIDTH (LINE_WIDTH),
      .DEPTH_W    (DEPTH_W),
      .ADDR_W     (ADDR_W)
   ) u_ram (
      .aclk    (out_stream_aclk),
      .we      (ram_we),
      .wr_addr ({wb, wr_addr}),
      .wr_data (wr_depth),
      .re      (fetch),
      .rd_addr ({rb, x_fetch}),
      .rd_data (depth_p0)
   );

   // Writer / reader FSMs, bank states and the read-stage tags
   always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
      if (!periph_resetn) begin
         wr_st      <= W_WAIT;
         rd_st      <= R_IDLE;
         bank_st[0] <= EMPTY;
         bank_st[1] <= EMPTY;
         wb         <= 1'b0;
         rb         <= 1'b0;
         start_line <= 1'b0;
         err        <= 1'b0;
         x_fetch    <= '0;
         fetching   <= 1'b0;
         rd_y       <= '0;
         vld_p0     <= 1'b0;
         eol_p0     <= 1'b0;
         sof_p0     <= 1'b0;
      end else begin
         start_line <= 1'b0;

         case (wr_st)
            W_WAIT: begin
               if (wr_en || wr_line_done)
                  err <= 1'b1;
               if (bank_st[wb] == EMPTY) begin
                  start_line  <= 1'b1;
                  bank_st[wb] <= FILLING;
                  wr_st       <= W_BUSY;
               end
            end
            W_BUSY: begin
               if (wr_en && !addr_ok)
                  err <= 1'b1;
               if (wr_line_done) begin
                  bank_st[wb] <= FULL;
                  wb          <= ~wb;
                  wr_st       <= W_WAIT;
               end
            end
            default: wr_st <= W_WAIT;
         endcase

         vld_p0 <= fetch;
         eol_p0 <= fetch && (x_fetch == X_LAST);
         sof_p0 <= fetch && (x_fetch == '0) && (rd_y == '0);

         case (rd_st)
            R_IDLE: begin
               if (bank_st[rb] == FULL) begin
                  bank_st[rb] <= DRAINING;
                  x_fetch     <= '0;
                  fetching    <= 1'b1;
                  rd_st       <= R_DRAIN;
               end
            end
            R_DRAIN: begin
               if (fetch) begin
                  x_fetch <= x_fetch + 1'b1;
                  if (x_fetch == X_LAST)
                     fetching <= 1'b0;
               end
               if (last_pop) begin
                  bank_st[rb] <= EMPTY;
                  rb          <= ~rb;
                  rd_st       <= R_IDLE;
                  rd_y        <= (rd_y == Y_LAST) ? '0 : rd_y + 1'b1;
               end
            end
            default: rd_st <= R_IDLE;
         endcase
      end
   end

   // Skid queue head: drives the rd_* outputs directly
   always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
      if (!periph_resetn) begin
         q_cnt    <= 2'd0;
         hd_depth <= '0;
         hd_eol   <= 1'b0;
         hd_sof   <= 1'b0;
      end else begin
         q_cnt <= (q_cnt + {1'b0, vld_p0}) - {1'b0, pop};
         if (pop && (q_cnt == 2'd2)) begin
            hd_depth <= tl_depth;
            hd_eol   <= tl_eol;
            hd_sof   <= tl_sof;
         end else if (vld_p0 && (pop || (q_cnt == 2'd0))) begin
            hd_depth <= depth_p0;
            hd_eol   <= eol_p0;
            hd_sof   <= sof_p0;
         end
      end
   end

   // Skid queue tail
   always_ff @(posedge out_stream_aclk) begin
      if (vld_p0 && ((q_cnt == 2'd2) || ((q_cnt == 2'd1) && !pop))) begin
         tl_depth <= depth_p0;
         tl_eol   <= eol_p0;
         tl_sof   <= sof_p0;
      end
   end

endmodule

// File: tb/tb_depth_line_buffer.sv
// Randomized bench for depth_line_buffer with a line-level reference model.
module tb_depth_line_buffer;

   localparam int LW      = 640;
   localparam int LINES_T = 8;
   localparam int SLOTS   = 4;
   localparam int YW      = $clog2(LINES_T);

   logic          clk = 1'b0;
   logic          periph_resetn;
   logic          wr_en;
   logic [9:0]    wr_addr;
   logic [9:0]    wr_depth;
   logic          wr_line_done;
   logic          start_line;
   logic [9:0]    rd_depth;
   logic          rd_valid;
   logic          rd_ready;
   logic          rd_eol;
   logic          rd_sof;
   logic [YW-1:0] rd_y;
   logic          err;

   int n_checks = 0;
   int n_errors = 0;
   int cyc_n = 0;
   int rdy_mode = 1;

   logic [9:0] exp_depth [SLOTS][LW];
   int lines_pushed = 0;
   int starts_used = 0;
   int done_edge = 0;

   int lines_popped = 0;
   int pix_x = 0;
   int start_cnt = 0;
   int last_start_edge = 0;
   int last_eol_edge = 0;

   depth_line_buffer #(
      .LINE_WIDTH (LW),
      .LINES      (LINES_T)
   ) dut (
      .out_stream_aclk (clk),
      .periph_resetn   (periph_resetn),
      .wr_en           (wr_en),
      .wr_addr         (wr_addr),
      .wr_depth        (wr_depth),
      .wr_line_done    (wr_line_done),
      .start_line      (start_line),
      .rd_depth        (rd_depth),
      .rd_valid        (rd_valid),
      .rd_ready        (rd_ready),
      .rd_eol          (rd_eol),
      .rd_sof          (rd_sof),
      .rd_y            (rd_y),
      .err             (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc_n);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Consumer ready pattern
   initial begin
      rd_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       rd_ready = 1'b0;
            1:       rd_ready = 1'b1;
            default: rd_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Output monitor: compares every accepted pixel against the model lines
   initial begin
      logic       prev_stall = 1'b0;
      logic       prev_start = 1'b0;
      logic [9:0] sv_depth = '0;
      logic       sv_eol = 1'b0;
      logic       sv_sof = 1'b0;
      int         sv_y = 0;
      int         y;
      forever begin
         @(negedge clk);
         if (!periph_resetn) begin
            start_cnt    = 0;
            lines_popped = 0;
            pix_x        = 0;
            prev_stall   = 1'b0;
            prev_start   = 1'b0;
         end else begin
            if (start_line) begin
               chk("start_width", int'(prev_start), 0);
               start_cnt++;
               last_start_edge = cyc_n;
            end
            prev_start = start_line;
            if (prev_stall) begin
               chk("stall_valid", int'(rd_valid), 1);
               chk("stall_depth", int'(rd_depth), int'(sv_depth));
               chk("stall_eol", int'(rd_eol), int'(sv_eol));
               chk("stall_sof", int'(rd_sof), int'(sv_sof));
               chk("stall_y", int'(rd_y), sv_y);
            end
            if (rd_valid && rd_ready) begin
               chk("line_pending", int'(lines_popped < lines_pushed), 1);
               if (lines_popped < lines_pushed) begin
                  y = lines_popped % LINES_T;
                  chk("pix_depth", int'(rd_depth), int'(exp_depth[lines_popped % SLOTS][pix_x]));
                  chk("pix_eol", int'(rd_eol), int'(pix_x == LW - 1));
                  chk("pix_sof", int'(rd_sof), int'(pix_x == 0 && y == 0));
                  chk("pix_y", int'(rd_y), y);
                  if (pix_x == LW - 1) begin
                     pix_x = 0;
                     lines_popped++;
                     last_eol_edge = cyc_n + 1;
                  end else begin
                     pix_x++;
                  end
               end
            end
            prev_stall = rd_valid && !rd_ready;
            sv_depth = rd_depth;
            sv_eol = rd_eol;
            sv_sof = rd_sof;
            sv_y = int'(rd_y);
         end
      end
   end

   task automatic do_reset(input bit wen_at_release);
      periph_resetn = 1'b0;
      wr_en = 1'b0;
      wr_line_done = 1'b0;
      wr_addr = '0;
      wr_depth = '0;
      lines_pushed = 0;
      starts_used = 0;
      repeat (3) cyc();
      chk("rst_start", int'(start_line), 0);
      chk("rst_valid", int'(rd_valid), 0);
      chk("rst_eol", int'(rd_eol), 0);
      chk("rst_sof", int'(rd_sof), 0);
      chk("rst_depth", int'(rd_depth), 0);
      chk("rst_y", int'(rd_y), 0);
      chk("rst_err", int'(err), 0);
      if (wen_at_release) begin
         wr_en = 1'b1;
         wr_addr = 10'd5;
         wr_depth = 10'h155;
      end
      periph_resetn = 1'b1;
      cyc();
      wr_en = 1'b0;
      chk("first_start", int'(start_line), 1);
   endtask

   task automatic fill_line(input bit shuffle, input bit rnd_data, input bit last_done,
                            input bit bad_addr, input bit spur_done);
      int order [LW];
      int slot;
      int j;
      int tmp;
      slot = lines_pushed % SLOTS;
      for (int x = 0; x < LW; x++) begin
         exp_depth[slot][x] = rnd_data ? 10'($urandom_range(0, 1023)) : 10'(x);
         order[x] = LW - 1 - x;
      end
      if (shuffle) begin
         for (int k = LW - 1; k > 0; k--) begin
            j = $urandom_range(0, k);
            tmp = order[k];
            order[k] = order[j];
            order[j] = tmp;
         end
      end
      for (int t = 0; t < 4000 && start_cnt <= starts_used; t++) cyc();
      chk("start_pulse", int'(start_cnt > starts_used), 1);
      starts_used++;
      for (int k = 0; k < LW; k++) begin
         if (bad_addr && k == LW / 2) begin
            wr_en = 1'b1;
            wr_addr = 10'd700;
            wr_depth = 10'h3ff;
            wr_line_done = 1'b0;
            cyc();
         end
         wr_en = 1'b1;
         wr_addr = 10'(order[k]);
         wr_depth = exp_depth[slot][order[k]];
         wr_line_done = last_done && (k == LW - 1);
         cyc();
      end
      wr_en = 1'b0;
      if (!last_done) begin
         wr_line_done = 1'b1;
         cyc();
      end
      wr_line_done = 1'b0;
      done_edge = cyc_n;
      lines_pushed++;
      if (spur_done) begin
         wr_line_done = 1'b1;
         cyc();
         wr_line_done = 1'b0;
      end
   endtask

   task automatic drain_wait();
      for (int t = 0; t < 6000 && lines_popped < lines_pushed; t++) cyc();
      chk("drained", lines_popped, lines_pushed);
   endtask

   initial begin
      periph_resetn = 1'b0;
      wr_en = 1'b0;
      wr_addr = '0;
      wr_depth = '0;
      wr_line_done = 1'b0;

      // Descending writes with depth = addr; latency and second start pulse
      rdy_mode = 1;
      do_reset(1'b0);
      fill_line(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc();
      chk("start_after_done", int'(start_line), 1);
      chk("lat_t1_valid", int'(rd_valid), 0);
      cyc();
      chk("lat_t2_valid", int'(rd_valid), 0);
      cyc();
      chk("lat_t3_valid", int'(rd_valid), 1);
      chk("lat_t3_sof", int'(rd_sof), 1);
      chk("lat_t3_depth", int'(rd_depth), 0);
      drain_wait();

      // Random ready, random order and data, three lines
      do_reset(1'b0);
      rdy_mode = 2;
      for (int l = 0; l < 3; l++) fill_line(1'b1, 1'b1, l == 1, 1'b0, 1'b0);
      drain_wait();
      chk("three_lines", lines_popped, 3);

      // Back-pressure: third start only after first line drains
      do_reset(1'b0);
      rdy_mode = 0;
      fill_line(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      fill_line(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      repeat (40) cyc();
      chk("no_third_start", start_cnt, starts_used);
      chk("held_valid", int'(rd_valid), 1);
      rdy_mode = 1;
      for (int t = 0; t < 3000 && start_cnt <= starts_used; t++) cyc();
      chk("third_start_delay", last_start_edge - last_eol_edge, 1);
      fill_line(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      drain_wait();

      // Protocol errors: write before start, address out of range, stray done
      do_reset(1'b1);
      chk("err_early_wr", int'(err), 1);
      fill_line(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      drain_wait();
      chk("err_sticky_a", int'(err), 1);

      do_reset(1'b0);
      chk("err_clear_b", int'(err), 0);
      fill_line(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("err_bad_addr", int'(err), 1);
      fill_line(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      drain_wait();
      chk("err_sticky_b", int'(err), 1);

      do_reset(1'b0);
      chk("err_clear_c", int'(err), 0);
      fill_line(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("err_stray_done", int'(err), 1);
      fill_line(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      drain_wait();
      chk("err_sticky_c", int'(err), 1);

      // Line counter wrap
      do_reset(1'b0);
      rdy_mode = 1;
      for (int l = 0; l < LINES_T + 1; l++) fill_line(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      drain_wait();
      chk("wrap_lines", lines_popped, LINES_T + 1);
      chk("wrap_rd_y", int'(rd_y), 1);

      // Asynchronous reset in the middle of a drain
      fill_line(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int t = 0; t < 3000 && pix_x < 300; t++) cyc();
      chk("reach_px300", int'(pix_x >= 300), 1);
      #2;
      periph_resetn = 1'b0;
      #1;
      chk("async_valid", int'(rd_valid), 0);
      chk("async_depth", int'(rd_depth), 0);
      chk("async_y", int'(rd_y), 0);
      chk("async_eol", int'(rd_eol), 0);
      chk("async_sof", int'(rd_sof), 0);
      chk("async_start", int'(start_line), 0);
      do_reset(1'b0);
      fill_line(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      drain_wait();
      chk("post_rst_line", lines_popped, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc_n);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/depth_line_buffer.md
# depth_line_buffer

Ping-pong line buffer between the parallel Mandelbrot engine array (`engine_top`) and the colour-lookup stage. It captures one line of escape depths, written out of order by the engines, into one of two banks. It then streams that line in pixel order over a valid/ready handshake while the engines fill the other bank. It also issues the engines' per-line start pulse, so compute of line N+1 overlaps display of line N.

## Interface
- `LINE_WIDTH`, 640: pixels per line.
- `LINES`, 480: lines per frame.
- `DEPTH_W`, 10: depth word width.
- `ADDR_W`, $clog2(LINE_WIDTH): pixel address width.
- `Y_W`, $clog2(LINES): line counter width.

Ports:
- `out_stream_aclk`  in  1  sole clock.
- `periph_resetn`  in  1  reset, asynchronous, active-low.
- `wr_en`  in  1  engine result write strobe.
- `wr_addr`  in  ADDR_W  pixel index of the write.
- `wr_depth`  in  DEPTH_W  depth value to write.
- `wr_line_done`  in  1  one-cycle pulse: current write bank is complete.
- `start_line`  out  1  one-cycle pulse: engines may begin the next line.
- `rd_depth`  out  DEPTH_W  depth of the current output pixel.
- `rd_valid`  out  1  output holds a pixel.
- `rd_ready`  in  1  consumer accepts the pixel.
- `rd_eol`  out  1  output pixel is x = LINE_WIDTH-1.
- `rd_sof`  out  1  output pixel is x = 0, y = 0.
- `rd_y`  out  Y_W  line index of the output pixel.
- `err`  out  1  sticky protocol-error flag.

## Operation
- Storage: two banks of LINE_WIDTH × DEPTH_W. Each bank has a state EMPTY, FILLING, FULL or DRAINING. RAM contents are not reset.
- Writer FSM:
  - States W_WAIT and W_BUSY, plus a write-bank pointer `wb` (reset 0).
  - In W_WAIT, when bank `wb` is EMPTY: pulse `start_line` for one cycle, set the bank to FILLING, go to W_BUSY.
  - In W_BUSY, `wr_en` writes `wr_depth` to bank `wb` at `wr_addr`.
  - In W_BUSY, `wr_line_done` sets the bank to FULL, toggles `wb` and returns to W_WAIT.
- Reader FSM:
  - States R_IDLE and R_DRAIN, plus a read-bank pointer `rb` (reset 0) and a fetch counter x (0..LINE_WIDTH-1).
  - In R_IDLE, when bank `rb` is FULL: set it to DRAINING, x = 0, go to R_DRAIN.
  - In R_DRAIN, issue a RAM read at x and increment x, whenever the output queue has room.
  - The last fetch is at x = LINE_WIDTH-1. When the pixel tagged eol is accepted, set the bank to EMPTY, toggle `rb` and go to R_IDLE.
- Output queue: 2-entry skid queue after the 1-cycle RAM read. Each entry carries depth, eol, sof and y. `rd_*` show the queue head.
- Line counter `rd_y` increments when an eol pixel is accepted, and wraps from LINES-1 to 0.
- `rd_sof` = head has x = 0 and y = 0. `rd_eol` = head has x = LINE_WIDTH-1.
- Errors set `err` and the offending input is dropped; `err` clears only on reset. Error cases:
  - `wr_en` in W_WAIT.
  - `wr_addr` ≥ LINE_WIDTH.
  - `wr_line_done` in W_WAIT.
- Simultaneous events:
  - `wr_line_done` and final-pixel accept in the same cycle: both take effect.
  - A bank that becomes EMPTY at edge t can trigger `start_line` at edge t+1 at the earliest.

## Timing
- Reset values:
  - `start_line`, `rd_valid`, `rd_eol`, `rd_sof`, `err` = 0.
  - `rd_depth`, `rd_y` = 0.
  - Both banks EMPTY, FSMs W_WAIT and R_IDLE.
- Reset may assert at any time and aborts the line immediately. The first `start_line` pulse is on the first rising edge after `periph_resetn` deasserts.
- `start_line` is high for exactly one cycle per line.
- Fill-to-output latency: `wr_line_done` sampled at edge t → bank FULL at t → R_DRAIN at t+1 → `rd_valid` high after edge t+3.
- Throughput: with `rd_ready` held high, one pixel per cycle and no bubbles within a line.
- Between lines there are at least 2 idle cycles.
- Handshake: a transfer occurs when `rd_valid` & `rd_ready`. While `rd_valid` & !`rd_ready`, all `rd_*` outputs stay stable.
- Writes are registered into the RAM. A write in the same cycle as `wr_line_done` is accepted.

## Structure
- Shared package `mandel_pkg` holds:
  - LINE_WIDTH, LINES, DEPTH_W.
  - The `bank_state_t` enum (EMPTY, FILLING, FULL, DRAINING).
  - The writer and reader FSM state enums.
- Sub-module `depth_bank_ram`: simple dual-port RAM with 2·LINE_WIDTH entries, address {bank, x}, registered write, 1-cycle synchronous read, BRAM-inferable.
- The top level holds the FSMs, the bank-state registers, the counters and the skid queue.

## Test plan
- Release reset, then write addresses 639 down to 0 with depth = addr, then pulse `wr_line_done`, with `rd_ready` = 1 → `start_line` at cycle 1 and again 1 cycle after done. Output is 640 pixels with `rd_depth` 0..639 in order, `rd_sof` on the first, `rd_eol` on the last, `rd_y` = 0.
- Drive `rd_ready` with a random 50% duty while filling three lines → exact ordered data, outputs stable while stalled, `rd_y` 0, 1, 2.
- Hold `rd_ready` = 0 while two lines fill → no third `start_line` until the first line fully drains; then `start_line` exactly 1 cycle after the last-pixel accept edge.
- Write with `wr_en` before the first `start_line`, with `wr_addr` = 700, and with a spurious `wr_line_done` → `err` = 1 and stays set; the RAM contents of the valid line are unaffected.
- Run 480 lines → `rd_y` wraps 479→0 and `rd_sof` reasserts on line 0, x = 0.
- Assert reset mid-drain at pixel 300 → all outputs 0 asynchronously. After release, a fresh `start_line` and a clean line from x = 0.
